// File: rtl/legv8_bus_ram.sv
// legv8_bus_ram: byte-addressed little-endian data memory slave
// on the LEGv8 shared tri-state bus, with optional wait states.
module legv8_bus_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic        ready,
  output logic        error
);

  localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

  logic [63:0]   mem [DEPTH];

  logic [32:0]   diff;
  logic [31:0]   offset;
  logic [2:0]    lane;
  logic [IW-1:0] row;
  logic          valid;
  logic          in_range;
  logic          misaligned;
  logic          err;
  logic          commit;
  logic          drive;
  logic          we;
  logic [7:0]    size_bytes;
  logic [7:0]    wmask;
  logic [63:0]   size_mask;
  logic [63:0]   row_data;
  logic [63:0]   rdata;
  logic [63:0]   wdata;

  assign valid    = mem_read | mem_write;
  assign diff     = {1'b0, address} - {1'b0, BASE_ADDR};
  assign offset   = diff[31:0];
  assign lane     = offset[2:0];
  assign row      = offset[IW+2:3];
  // a borrow out of the subtraction means address < BASE_ADDR
  assign in_range = ~diff[32] & ({1'b0, offset} < SPAN);

  // access size: byte footprint, zero-extend mask, alignment
  always_comb begin
    size_bytes = 8'h01;
    size_mask  = 64'h0000_0000_0000_00FF;
    misaligned = 1'b0;
    unique case (size)
      2'b00: begin
        size_bytes = 8'h01;
        size_mask  = 64'h0000_0000_0000_00FF;
        misaligned = 1'b0;
      end
      2'b01: begin
        size_bytes = 8'h03;
        size_mask  = 64'h0000_0000_0000_FFFF;
        misaligned = lane[0];
      end
      2'b10: begin
        size_bytes = 8'h0F;
        size_mask  = 64'h0000_0000_FFFF_FFFF;
        misaligned = |lane[1:0];
      end
      2'b11: begin
        size_bytes = 8'hFF;
        size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        misaligned = |lane;
      end
    endcase
  end

  assign err      = (mem_read & mem_write) | ~in_range | misaligned;
  assign row_data = mem[row];
  assign rdata    = err ? 64'h0
                  : (row_data >> {lane, 3'b000}) & size_mask;
  assign wmask    = size_bytes << lane;
  assign wdata    = data << {lane, 3'b000};
  assign we       = reset & mem_write & ~err & commit;
  assign data     = drive ? rdata : 64'hz;

  // byte-enabled synchronous write; contents survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        if (wmask[k]) begin
          mem[row][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  if (WAIT_STATES == 0) begin : g_zero

    assign ready  = 1'b1;
    assign error  = valid & err;
    assign commit = 1'b1;
    assign drive  = reset & mem_read;

  end else begin : g_wait

    typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_t     state;
    logic [3:0] cnt;

    // wait-state sequencer; a dropped request abandons the access
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (valid) begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!valid) begin
              state <= S_IDLE;
            end else if (cnt == 4'd0) begin
              state <= S_DONE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end

    assign ready  = (state == S_IDLE) ? ~valid
                  : (state == S_DONE);
    assign error  = (state == S_DONE) & valid & err;
    assign commit = (state == S_DONE);
    assign drive  = reset & mem_read & (state == S_DONE);

  end

endmodule

// File: tb/tb_legv8_bus_ram.sv
// tb_legv8_bus_ram: zero-wait and 3-wait instances checked
// against a byte-array memory model with random accesses.
module tb_legv8_bus_ram;

  localparam logic [31:0] B0    = 32'h0000_0100;
  localparam logic [31:0] B3    = 32'h0000_0000;
  localparam int          DEPTH = 256;
  localparam int          SPAN  = DEPTH * 8;
  localparam int          WS    = 3;
  localparam logic [63:0] REL   = '1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr0 = '0;
  logic [31:0] addr3 = '0;
  logic        rd0   = 1'b0;
  logic        wr0   = 1'b0;
  logic        rd3   = 1'b0;
  logic        wr3   = 1'b0;
  logic        oe0   = 1'b0;
  logic        oe3   = 1'b0;
  logic [1:0]  sz0   = '0;
  logic [1:0]  sz3   = '0;
  logic [63:0] drv0  = '0;
  logic [63:0] drv3  = '0;
  wire  [63:0] bus0;
  wire  [63:0] bus3;
  logic        rdy0;
  logic        err0;
  logic        rdy3;
  logic        err3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [2][SPAN];

  always #5 clk = ~clk;

  assign bus0 = oe0 ? drv0 : 64'hz;
  assign bus3 = oe3 ? drv3 : 64'hz;
  pullup (bus0);
  pullup (bus3);

  legv8_bus_ram #(
    .BASE_ADDR   (B0),
    .DEPTH       (DEPTH),
    .WAIT_STATES (0)
  ) u0 (
    .clock     (clk),
    .reset     (rst_n),
    .address   (addr0),
    .data      (bus0),
    .mem_read  (rd0),
    .mem_write (wr0),
    .size      (sz0),
    .ready     (rdy0),
    .error     (err0)
  );

  legv8_bus_ram #(
    .BASE_ADDR   (B3),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) u3 (
    .clock     (clk),
    .reset     (rst_n),
    .address   (addr3),
    .data      (bus3),
    .mem_read  (rd3),
    .mem_write (wr3),
    .size      (sz3),
    .ready     (rdy3),
    .error     (err3)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint moff(input int u, input logic [31:0] a);
    logic [31:0] b;
    b = (u == 1) ? B3 : B0;
    return longint'({32'h0, a}) - longint'({32'h0, b});
  endfunction

  function automatic logic merr(input int u, input logic [31:0] a,
                                input logic [1:0] sz,
                                input logic rd, input logic wr);
    longint off;
    int     n;
    off = moff(u, a);
    n   = 1 << sz;
    return (rd && wr) || off < 0 || off >= SPAN || (off % n) != 0;
  endfunction

  function automatic logic [63:0] mread(input int u,
                                        input logic [31:0] a,
                                        input logic [1:0] sz,
                                        input logic rd, input logic wr);
    logic [63:0] v;
    int          off;
    v = '0;
    if (merr(u, a, sz, rd, wr)) return v;
    off = int'(moff(u, a));
    for (int k = 0; k < (1 << sz); k++) v[8*k +: 8] = mdl[u][off+k];
    return v;
  endfunction

  task automatic mwrite(input int u, input logic [31:0] a,
                        input logic [1:0] sz, input logic [63:0] d);
    int off;
    off = int'(moff(u, a));
    for (int k = 0; k < (1 << sz); k++) mdl[u][off+k] = d[8*k +: 8];
  endtask

  task automatic acc0(input logic rd, input logic wr,
                      input logic [31:0] a, input logic [1:0] sz,
                      input logic [63:0] d, input string tag,
                      output logic [63:0] got);
    logic        e;
    logic [63:0] x;
    @(negedge clk);
    addr0 = a; sz0 = sz; rd0 = rd; wr0 = wr;
    drv0  = d; oe0 = wr & ~rd;
    e = merr(0, a, sz, rd, wr);
    x = mread(0, a, sz, rd, wr);
    #2;
    got = bus0;
    chk({tag, ".rdy"}, 64'(rdy0), 64'd1);
    chk({tag, ".err"}, 64'(err0), 64'(e));
    if (rd) chk({tag, ".dat"}, bus0, x);
    @(posedge clk);
    #1;
    if (wr && !e) mwrite(0, a, sz, d);
    rd0 = 1'b0; wr0 = 1'b0; oe0 = 1'b0;
    #1;
    chk({tag, ".rel"}, bus0, REL);
  endtask

  task automatic acc3(input logic rd, input logic wr,
                      input logic [31:0] a, input logic [1:0] sz,
                      input logic [63:0] d, input string tag,
                      output logic [63:0] got);
    logic        e;
    logic [63:0] x;
    int          lat;
    @(negedge clk);
    addr3 = a; sz3 = sz; rd3 = rd; wr3 = wr;
    drv3  = d; oe3 = wr & ~rd;
    e   = merr(1, a, sz, rd, wr);
    x   = mread(1, a, sz, rd, wr);
    lat = 0;
    #2;
    while (!rdy3) begin
      if (rd) chk({tag, ".hiz"}, bus3, REL);
      lat++;
      if (lat > 20) begin
        chk({tag, ".timeout"}, 64'(lat), 64'(WS + 1));
        break;
      end
      @(negedge clk);
      #2;
    end
    got = bus3;
    chk({tag, ".lat"}, 64'(lat), 64'(WS + 1));
    chk({tag, ".err"}, 64'(err3), 64'(e));
    if (rd) chk({tag, ".dat"}, bus3, x);
    @(posedge clk);
    #1;
    if (wr && !e) mwrite(1, a, sz, d);
    rd3 = 1'b0; wr3 = 1'b0; oe3 = 1'b0;
    #1;
    chk({tag, ".idle"}, 64'(rdy3), 64'd1);
    chk({tag, ".rel"}, bus3, REL);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g;
    logic [31:0] a;
    logic [31:0] base;
    logic [1:0]  sz;
    logic [63:0] d;
    int          u;
    int          r;
    int          ln;
    int          op;

    #1;
    rst_n = 1'b0;
    rd0   = 1'b1;
    addr0 = B0;
    #2;
    chk("rst.rdy0", 64'(rdy0), 64'd1);
    chk("rst.rdy3", 64'(rdy3), 64'd1);
    chk("rst.err3", 64'(err3), 64'd0);
    chk("rst.bus0", bus0, REL);
    rd0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < DEPTH; k++) begin
      if (k < 16 || k >= DEPTH - 2) begin
        acc0(1'b0, 1'b1, B0 + 32'(k * 8), 2'b11,
             {$urandom, $urandom}, "pre0", g);
        acc3(1'b0, 1'b1, B3 + 32'(k * 8), 2'b11,
             {$urandom, $urandom}, "pre3", g);
      end
    end

    acc0(1'b0, 1'b1, B0 + 32'd24, 2'b11, 64'hFFFF_FFFF_FFFF_FFE8, "w24", g);
    acc0(1'b1, 1'b0, B0 + 32'd24, 2'b11, 64'h0, "r24", g);
    chk("r24.k", g, 64'hFFFF_FFFF_FFFF_FFE8);

    acc0(1'b0, 1'b1, B0 + 32'd8, 2'b11, 64'h0, "wz8", g);
    acc0(1'b0, 1'b1, B0 + 32'd13, 2'b00, 64'h77AB, "wb13", g);
    acc0(1'b0, 1'b1, B0 + 32'd10, 2'b01, 64'h9999_1234, "wh10", g);
    acc0(1'b1, 1'b0, B0 + 32'd8, 2'b11, 64'h0, "rd8", g);
    chk("rd8.k", g, 64'h0000_AB00_1234_0000);
    acc0(1'b1, 1'b0, B0 + 32'd13, 2'b00, 64'h0, "rb13", g);
    chk("rb13.k", g, 64'h0000_0000_0000_00AB);

    acc0(1'b1, 1'b0, B0 + 32'd9, 2'b01, 64'h0, "emis", g);
    chk("emis.k", g, 64'h0);
    acc0(1'b1, 1'b0, B0 + 32'(SPAN), 2'b11, 64'h0, "eoor", g);
    chk("eoor.k", g, 64'h0);
    acc0(1'b1, 1'b1, B0 + 32'd24, 2'b11, 64'h0, "erw", g);
    chk("erw.k", g, 64'h0);
    acc0(1'b0, 1'b1, B0 - 32'd8, 2'b11, 64'h1, "elow", g);
    acc0(1'b1, 1'b0, B0 + 32'd24, 2'b11, 64'h0, "r24b", g);
    chk("r24b.k", g, 64'hFFFF_FFFF_FFFF_FFE8);

    acc3(1'b0, 1'b1, B3 + 32'd24, 2'b11, 64'hFFFF_FFFF_FFFF_FFE8, "w3", g);
    acc3(1'b1, 1'b0, B3 + 32'd24, 2'b11, 64'h0, "r3", g);
    chk("r3.k", g, 64'hFFFF_FFFF_FFFF_FFE8);
    acc3(1'b1, 1'b0, B3 + 32'd9, 2'b01, 64'h0, "e3mis", g);
    chk("e3mis.k", g, 64'h0);
    acc3(1'b1, 1'b1, B3 + 32'd24, 2'b11, 64'h0, "e3rw", g);
    chk("e3rw.k", g, 64'h0);
    acc3(1'b1, 1'b0, B3 + 32'(SPAN), 2'b11, 64'h0, "e3oor", g);

    @(negedge clk);
    addr3 = B3; sz3 = 2'b11; wr3 = 1'b1;
    drv3  = 64'h55; oe3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst3.wait", 64'(rdy3), 64'd0);
    rst_n = 1'b0;
    wr3   = 1'b0;
    oe3   = 1'b0;
    #1;
    chk("rst3.rdy", 64'(rdy3), 64'd1);
    chk("rst3.err", 64'(err3), 64'd0);
    chk("rst3.bus", bus3, REL);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc3(1'b1, 1'b0, B3, 2'b11, 64'h0, "rst3.rd", g);

    @(negedge clk);
    addr3 = B3 + 32'd32; sz3 = 2'b11; wr3 = 1'b1;
    drv3  = 64'hDEAD_BEEF_0BAD_F00D; oe3 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    wr3 = 1'b0;
    oe3 = 1'b0;
    #2;
    chk("drop.wait", 64'(rdy3), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk("drop.idle", 64'(rdy3), 64'd1);
    end
    acc3(1'b1, 1'b0, B3 + 32'd32, 2'b11, 64'h0, "drop.rd", g);

    for (int i = 0; i < 160; i++) begin
      u    = i % 2;
      base = (u == 1) ? B3 : B0;
      r    = int'($urandom_range(0, 99));
      sz   = 2'($urandom_range(0, 3));
      ln   = int'(($urandom_range(0, 7) >> sz) << sz);
      if ($urandom_range(0, 5) == 0) ln = int'($urandom_range(0, 7));
      if (r < 75)
        a = base + 32'(int'($urandom_range(0, 15)) * 8 + ln);
      else if (r < 88)
        a = base + 32'(SPAN - 16 + int'($urandom_range(0, 1)) * 8 + ln);
      else if (r < 94)
        a = base + 32'(SPAN + int'($urandom_range(0, 31)));
      else
        a = base - 32'($urandom_range(1, 32));
      op = int'($urandom_range(0, 19));
      d  = {$urandom, $urandom};
      if (u == 0)
        acc0(op < 10, op == 0 || op >= 10, a, sz, d, "rnd0", g);
      else
        acc3(op < 10, op == 0 || op >= 10, a, sz, d, "rnd3", g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
